// File: rtl/riscv_pipe_pkg.sv
// Shared IF/ID pipeline types: the fetch packet layout and the NOP encoding
// that marks an empty decode slot.
package riscv_pipe_pkg;

    // addi x0, x0, 0 -- rd=0, so the hazard detector never matches it
    localparam logic [31:0] NOP_OPCODE = 32'h00000013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] opcode;
    } fetch_pkt_t;

    // Invalid packet carrying NOP; pc is preserved so dec_pc_o stays put
    function automatic fetch_pkt_t empty_pkt(input logic [31:0] pc);
        fetch_pkt_t p;
        p.valid  = 1'b0;
        p.pc     = pc;
        p.opcode = NOP_OPCODE;
        return p;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid buffer for the IF/ID boundary. Catches the packet that
// was already accepted when decode stalled, and hands it back on drain.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic       drain_i,
    input  fetch_pkt_t pkt_i,
    output fetch_pkt_t pkt_o,
    output logic       valid_next_o
);

    fetch_pkt_t entry_q;

    // Occupancy after the coming edge; feeds the registered fetch accept
    always_comb begin
        valid_next_o = 1'b0;
        if (reset_i || clear_i)
            valid_next_o = 1'b0;
        else if (load_i)
            valid_next_o = 1'b1;
        else
            valid_next_o = entry_q.valid && !drain_i;
    end

    // Entry register: clear beats load beats drain
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q       <= pkt_i;
            entry_q.valid <= 1'b1;
        end else if (drain_i) begin
            entry_q.valid <= 1'b0;
        end
    end

    assign pkt_o = entry_q;

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with one skid entry. Decode holds on a load-use
// stall, the in-flight fetch lands in the skid, and flush discards both.
// Optional feature: define IF_ID_PERF_EN to add the stall_cnt_o counter.
module if_id_skid
    import riscv_pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_opcode_i,
    output logic        fetch_accept_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        dec_valid_o,
    output logic [31:0] dec_pc_o,
    output logic [31:0] dec_opcode_o,
    output logic        exe_valid_o
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    fetch_pkt_t dec_q, dec_d;
    fetch_pkt_t skid_pkt, fetch_pkt;
    logic       accept_q;
    logic       take, hold, skid_load, skid_drain, skid_valid_next;

    assign fetch_pkt.valid  = fetch_valid_i;
    assign fetch_pkt.pc     = fetch_pc_i;
    assign fetch_pkt.opcode = fetch_opcode_i;

    // A stall only freezes decode when there is something live to freeze
    assign take       = fetch_valid_i && accept_q;
    assign hold       = stall_i && dec_q.valid;
    assign skid_load  = !flush_i && hold && take;
    assign skid_drain = !flush_i && !hold && skid_pkt.valid;

    pipe_skid_buf u_skid (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .load_i       (skid_load),
        .clear_i      (flush_i),
        .drain_i      (skid_drain),
        .pkt_i        (fetch_pkt),
        .pkt_o        (skid_pkt),
        .valid_next_o (skid_valid_next)
    );

    // Decode slot next-state: flush, hold, drain skid, take fetch, or empty
    always_comb begin
        dec_d = dec_q;
        if (flush_i)
            dec_d = empty_pkt(dec_q.pc);
        else if (hold)
            dec_d = dec_q;
        else if (skid_pkt.valid)
            dec_d = skid_pkt;
        else if (take)
            dec_d = fetch_pkt;
        else
            dec_d = empty_pkt(dec_q.pc);
    end

    // Decode register and registered accept (accept only while skid empty)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dec_q    <= empty_pkt(32'h0);
            accept_q <= 1'b1;
        end else begin
            dec_q    <= dec_d;
            accept_q <= !skid_valid_next;
        end
    end

    assign fetch_accept_o = accept_q;
    assign dec_valid_o    = dec_q.valid;
    assign dec_pc_o       = dec_q.pc;
    assign dec_opcode_o   = dec_q.opcode;
    assign exe_valid_o    = dec_q.valid && !stall_i && !flush_i;

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count real stall cycles (live decode, not flushed), saturating
    always_ff @(posedge clk_i) begin
        if (reset_i)
            stall_cnt_q <= 32'h0;
        else if (hold && !flush_i && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'h1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid. Accepted packets are queued in order and
// popped whenever the DUT issues to execute, so loss or duplication shows up.
module tb_if_id_skid;
    import riscv_pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i, fetch_valid_i, stall_i, flush_i;
    logic [31:0] fetch_pc_i, fetch_opcode_i;
    logic        fetch_accept_o, dec_valid_o, exe_valid_o;
    logic [31:0] dec_pc_o, dec_opcode_o;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    fetch_pkt_t exp_q[$];
    fetch_pkt_t exp;

    localparam logic [31:0] LW_X5 = 32'h0002A283;

    if_id_skid dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_opcode_i (fetch_opcode_i),
        .fetch_accept_o (fetch_accept_o),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .dec_valid_o    (dec_valid_o),
        .dec_pc_o       (dec_pc_o),
        .dec_opcode_o   (dec_opcode_o),
        .exe_valid_o    (exe_valid_o)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] op,
                         input logic st, input logic fl);
        fetch_valid_i  = v;
        fetch_pc_i     = pc;
        fetch_opcode_i = op;
        stall_i        = st;
        flush_i        = fl;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] op);
        fetch_pkt_t p;
        p.valid = 1'b1; p.pc = pc; p.opcode = op;
        exp_q.push_back(p);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        drive(1'b1, 32'hDEAD_0000, 32'h1234_5678, 1'b0, 1'b0);
        step(); step();
        checks++;
        if (dec_valid_o !== 1'b0 || dec_pc_o !== 32'h0 || dec_opcode_o !== NOP_OPCODE ||
            fetch_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b pc=%h op=%h acc=%b want v=0 pc=0 op=%h acc=1",
                     dec_valid_o, dec_pc_o, dec_opcode_o, fetch_accept_o, NOP_OPCODE);
        end
`ifdef IF_ID_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'h0) begin
            errors++; $display("FAIL reset_cnt got %h want 0", stall_cnt_o);
        end
`endif
        reset_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_q.delete();
        step();
        checks++;
        if (dec_valid_o !== 1'b0 || exe_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_idle got v=%b exe=%b want 0 0", dec_valid_o, exe_valid_o);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'h0000_0093 | 32'(i << 20), 1'b0, 1'b0);
            checks++;
            if (fetch_accept_o !== 1'b1) begin
                errors++; $display("FAIL stream_accept[%0d] got %b want 1", i, fetch_accept_o);
            end
            push(32'(4 * i), 32'h0000_0093 | 32'(i << 20));
            step();
            exp = exp_q.pop_front();
            checks++;
            if (exe_valid_o !== 1'b1 || dec_valid_o !== 1'b1 || dec_pc_o !== exp.pc ||
                dec_opcode_o !== exp.opcode) begin
                errors++;
                $display("FAIL stream_dec[%0d] got exe=%b v=%b pc=%h op=%h want 1 1 %h %h",
                         i, exe_valid_o, dec_valid_o, dec_pc_o, dec_opcode_o, exp.pc, exp.opcode);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (dec_valid_o !== 1'b0 || dec_opcode_o !== NOP_OPCODE || dec_pc_o !== 32'hC) begin
            errors++;
            $display("FAIL stream_drain got v=%b pc=%h op=%h want 0 0000000c %h",
                     dec_valid_o, dec_pc_o, dec_opcode_o, NOP_OPCODE);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h4, LW_X5, 1'b0, 1'b0);
        push(32'h4, LW_X5);
        step();
        drive(1'b1, 32'h8, 32'h0000_0113, 1'b1, 1'b0);
        #1;
        checks++;
        if (exe_valid_o !== 1'b0 || fetch_accept_o !== 1'b1 || dec_pc_o !== 32'h4) begin
            errors++; $display("FAIL stall_bubble got exe=%b acc=%b pc=%h want 0 1 00000004",
                               exe_valid_o, fetch_accept_o, dec_pc_o);
        end
        push(32'h8, 32'h0000_0113);
        step();
        checks++;
        if (dec_pc_o !== 32'h4 || dec_opcode_o !== LW_X5 || fetch_accept_o !== 1'b0) begin
            errors++; $display("FAIL stall_hold got pc=%h op=%h acc=%b want 00000004 %h 0",
                               dec_pc_o, dec_opcode_o, fetch_accept_o, LW_X5);
        end
        // 0xC is presented while accept is low: it must not be taken yet
        drive(1'b1, 32'hC, 32'h0000_0193, 1'b0, 1'b0);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (exe_valid_o !== 1'b1 || dec_pc_o !== exp.pc || dec_opcode_o !== exp.opcode) begin
            errors++; $display("FAIL stall_issue got exe=%b pc=%h want 1 %h", exe_valid_o, dec_pc_o, exp.pc);
        end
        step();
        exp = exp_q.pop_front();
        checks++;
        if (exe_valid_o !== 1'b1 || dec_pc_o !== exp.pc || dec_opcode_o !== exp.opcode ||
            fetch_accept_o !== 1'b1) begin
            errors++; $display("FAIL skid_drain got exe=%b pc=%h acc=%b want 1 %h 1",
                               exe_valid_o, dec_pc_o, fetch_accept_o, exp.pc);
        end
        push(32'hC, 32'h0000_0193);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (exe_valid_o !== 1'b1 || dec_pc_o !== exp.pc || dec_opcode_o !== exp.opcode) begin
            errors++; $display("FAIL post_skid got exe=%b pc=%h want 1 %h", exe_valid_o, dec_pc_o, exp.pc);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (dec_valid_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_end got v=%b left=%0d want 0 0", dec_valid_o, exp_q.size());
        end
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 32'h20, 32'h0000_0213, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h24, 32'h0000_0293, 1'b1, 1'b0);
        step();
        checks++;
        if (fetch_accept_o !== 1'b0) begin
            errors++; $display("FAIL flush_skid_full got acc=%b want 0", fetch_accept_o);
        end
        drive(1'b1, 32'h28, 32'h0000_0313, 1'b1, 1'b1);
        #1;
        checks++;
        if (exe_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_exe got %b want 0", exe_valid_o);
        end
        step();
        exp_q.delete();
        checks++;
        if (dec_valid_o !== 1'b0 || dec_opcode_o !== NOP_OPCODE || fetch_accept_o !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b op=%h acc=%b want 0 %h 1",
                               dec_valid_o, dec_opcode_o, fetch_accept_o, NOP_OPCODE);
        end
        // Accepted fetch in a flush cycle is dropped
        drive(1'b1, 32'h30, 32'h0000_0393, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (dec_valid_o !== 1'b0 || exe_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_no_stale got v=%b pc=%h want v=0", dec_valid_o, dec_pc_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'h40, 32'h0000_0413, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h44, 32'h0000_0493, 1'b1, 1'b0);
        step();
        reset_i = 1'b1;
        drive(1'b1, 32'h48, 32'h0000_0513, 1'b1, 1'b1);
        step();
        exp_q.delete();
        checks++;
        if (dec_valid_o !== 1'b0 || dec_pc_o !== 32'h0 || dec_opcode_o !== NOP_OPCODE ||
            fetch_accept_o !== 1'b1) begin
            errors++; $display("FAIL reset_stall got v=%b pc=%h op=%h acc=%b want 0 0 %h 1",
                               dec_valid_o, dec_pc_o, dec_opcode_o, fetch_accept_o, NOP_OPCODE);
        end
`ifdef IF_ID_PERF_EN
        checks++;
        if (stall_cnt_o !== 32'h0) begin
            errors++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt_o);
        end
`endif
        reset_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (dec_valid_o !== 1'b0) begin
                errors++; $display("FAIL reset_no_stale[%0d] got v=%b pc=%h want v=0", i, dec_valid_o, dec_pc_o);
            end
        end
    endtask

    task automatic test_stall_empty();
        logic [31:0] cnt0;
        cnt0 = 32'h0;
`ifdef IF_ID_PERF_EN
        cnt0 = stall_cnt_o;
`endif
        drive(1'b1, 32'h10, 32'h0000_0593, 1'b1, 1'b0);
        checks++;
        if (fetch_accept_o !== 1'b1) begin
            errors++; $display("FAIL stall_empty_acc got %b want 1", fetch_accept_o);
        end
        push(32'h10, 32'h0000_0593);
        step();
        checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h10 || exe_valid_o !== 1'b0) begin
            errors++; $display("FAIL stall_empty_load got v=%b pc=%h exe=%b want 1 00000010 0",
                               dec_valid_o, dec_pc_o, exe_valid_o);
        end
`ifdef IF_ID_PERF_EN
        checks++;
        if (stall_cnt_o !== cnt0) begin
            errors++; $display("FAIL stall_empty_cnt got %h want %h", stall_cnt_o, cnt0);
        end
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (exe_valid_o !== 1'b1 || dec_pc_o !== exp.pc || dec_opcode_o !== exp.opcode) begin
            errors++; $display("FAIL stall_empty_issue got exe=%b pc=%h want 1 %h", exe_valid_o, dec_pc_o, exp.pc);
        end
        step();
        checks++;
        if (dec_valid_o !== 1'b0 || cnt0 !== 32'h0 && 1'b0) begin
            errors++; $display("FAIL stall_empty_end got v=%b want 0", dec_valid_o);
        end
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_counter();
        reset_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        reset_i = 1'b0;
        exp_q.delete();
        drive(1'b1, 32'h50, 32'h0000_0613, 1'b0, 1'b0);
        push(32'h50, 32'h0000_0613);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(); step(); step();
        checks++;
        if (stall_cnt_o !== 32'd3) begin
            errors++; $display("FAIL cnt_three got %h want 00000003", stall_cnt_o);
        end
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        step();
        checks++;
        if (stall_cnt_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cnt_saturate got %h want ffffffff", stall_cnt_o);
        end
        stall_i = 1'b0;
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (exe_valid_o !== 1'b1 || dec_pc_o !== exp.pc) begin
            errors++; $display("FAIL cnt_issue got exe=%b pc=%h want 1 %h", exe_valid_o, dec_pc_o, exp.pc);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_stall();
        test_reset_mid_stall();
        test_stall_empty();
`ifdef IF_ID_PERF_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1, reset; it is synchronous and active-high.
REQ-003 SHALL have port fetch_valid_i, input, 1, a fetch packet is presented.
REQ-004 SHALL have port fetch_pc_i, input, 32, PC of the presented packet.
REQ-005 SHALL have port fetch_opcode_i, input, 32, instruction word of the presented packet.
REQ-006 SHALL have port fetch_accept_o, output, 1, packet taken this cycle when fetch_valid_i is also 1.
REQ-007 SHALL have port stall_i, input, 1, load-use stall from the hazard detector; hold decode, issue bubble.
REQ-008 SHALL have port flush_i, input, 1, branch/jump redirect; discard all held packets.
REQ-009 SHALL have port dec_valid_o, output, 1, decode slot holds a live instruction.
REQ-010 SHALL have port dec_pc_o, output, 32, PC of the decode slot.
REQ-011 SHALL have port dec_opcode_o, output, 32, instruction word to decode and to the hazard detector opcode_i.
REQ-012 SHALL have port exe_valid_o, output, 1, instruction issued to execute this cycle (0 = bubble).
REQ-013 SHALL have port stall_cnt_o, output, 32, stall-cycle count; present only with IF_ID_PERF_EN.

Function
REQ-014 SHALL hold two entries: decode slot (DEC) and one skid entry (SKID), each {valid, pc, opcode}.
REQ-015 SHALL drive fetch_accept_o registered, equal to !SKID.valid after the previous edge.
REQ-016 SHALL give 1-cycle latency: a packet accepted at edge N appears on dec_* after edge N, when no stall is active and SKID is empty.
REQ-017 SHALL drive exe_valid_o = dec_valid_o & !stall_i & !flush_i, combinationally.
REQ-018 SHALL keep DEC unchanged while stall_i=1 and dec_valid_o=1; an accepted packet in that cycle goes to SKID.
REQ-019 SHALL ignore stall_i when dec_valid_o=0; DEC loads normally.
REQ-020 SHALL, at the first edge with stall_i=0 and SKID valid, move SKID to DEC and clear SKID.
REQ-021 SHALL never accept a packet while SKID is valid; no packet is lost or duplicated.
REQ-022 SHALL, on flush_i=1, clear DEC.valid and SKID.valid, set dec_opcode_o to NOP 32'h00000013, and drop any packet presented that cycle.
REQ-023 SHALL give flush_i priority over stall_i and over a concurrent fetch.
REQ-024 SHALL set dec_opcode_o to NOP whenever DEC is loaded invalid (empty fetch cycle), so the hazard detector sees rd=0.
REQ-025 SHALL, when DEC empties and no fetch is valid, clear dec_valid_o and keep dec_pc_o at its last value.

Reset
REQ-026 SHALL, on reset_i=1 at an edge, set: dec_valid_o=0, dec_pc_o=0, dec_opcode_o=32'h00000013, SKID empty, fetch_accept_o=1, stall_cnt_o=0.
REQ-027 SHALL give reset priority over flush_i, stall_i and fetch; a packet in flight during reset is discarded.

Configuration
REQ-028 SHALL, with IF_ID_PERF_EN defined, count edges where stall_i=1 and dec_valid_o=1 and flush_i=0, saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without IF_ID_PERF_EN, omit stall_cnt_o and its counter entirely; all other behaviour is identical.

Structure
REQ-030 SHALL place the NOP constant 32'h00000013 and the packed typedef fetch_pkt_t {valid, pc[31:0], opcode[31:0]} in shared package riscv_pipe_pkg.
REQ-031 SHALL implement SKID as sub-module pipe_skid_buf (load, clear, drain controls; one fetch_pkt_t entry).

Verification
REQ-032 SHALL cover streaming: 4 back-to-back packets, PC 0x0,0x4,0x8,0xC -> each on dec_* one cycle later; exe_valid_o=1 continuously; fetch_accept_o=1 continuously.
REQ-033 SHALL cover a 1-cycle stall: stall_i=1 with DEC=(0x4, lw x5); packet 0x8 presented -> DEC holds 0x4; exe_valid_o=0; 0x8 enters SKID; fetch_accept_o=0 next cycle; 0x8 in DEC after stall drops.
REQ-034 SHALL cover flush during stall: SKID valid, stall_i=1, flush_i=1 -> next cycle dec_valid_o=0, dec_opcode_o=32'h00000013, fetch_accept_o=1.
REQ-035 SHALL cover reset mid-stall: reset_i=1 with SKID full -> all REQ-026 values after one edge; no stale packet emerges afterwards.
REQ-036 SHALL cover stall with empty decode: stall_i=1 and dec_valid_o=0 with packet 0x10 -> 0x10 loads into DEC; stall_cnt_o unchanged.
REQ-037 SHALL cover the counter (IF_ID_PERF_EN): 3 qualifying stall cycles -> stall_cnt_o=3; preload at 32'hFFFFFFFF plus one stall -> stays 32'hFFFFFFFF.
